frac_lutk_cfg: RTL and testbench

Parametrised fracturable K-input look-up table with its own serial configuration chain, load-sequencing FSM and registered outputs. It generalises the 4-input fracturable LUT: the input count is parametrised, and the block loads its truth table and mode bit from a daisy-chained bitstream. It tracks configuration validity and gates its outputs until a complete load has been seen. It sits inside each logic element of the eFPGA fabric and chains `cfg_dout` to the next tile's `cfg_din`.

---
 rtl/frac_lutk_cfg.sv | 117 +++++++++++
 tb/tb_frac_lutk_cfg.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frac_lutk_cfg.sv
// Fracturable K-input LUT with a daisy-chained serial configuration register,
// a load-tracking FSM, output gating until a complete load, and output registers.
module frac_lutk_cfg #(
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_en,
    input  logic         cfg_din,
    output logic         cfg_dout,
    output logic         cfg_done,
    output logic         cfg_err,
    input  logic [K-1:0] in,
    input  logic         ff_en,
    output logic         lut_out,
    output logic [1:0]   frac_out,
    output logic         q,
    output logic [1:0]   q_frac
);

    localparam int TW = 1 << K;
    localparam int N  = TW + 1;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(N);

    typedef enum logic [1:0] {
        UNCFG   = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2
    } state_t;

    state_t          state_reg;
    logic [N-1:0]    cfg_reg;
    logic [CW-1:0]   cnt_reg;
    logic            err_reg;
    logic            q_reg;
    logic [1:0]      q_frac_reg;

    logic [TW-1:0]   truth;
    logic            mode;
    logic            ready;
    logic            lut_raw;
    logic [1:0]      frac_raw;
    logic            lut_gated;
    logic [1:0]      frac_gated;

    // The first bit of a load ends up in the top position and acts as the mode bit.
    assign truth = cfg_reg[TW-1:0];
    assign mode  = cfg_reg[N-1];
    assign ready = (state_reg == READY);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_half
            localparam logic HALF = 1'(gi);
            assign frac_raw[gi] = truth[{HALF, in[K-2:0]}];
        end
    endgenerate

    assign lut_raw    = truth[{in[K-1] | mode, in[K-2:0]}];
    assign lut_gated  = ready & lut_raw;
    assign frac_gated = ready ? frac_raw : 2'b00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= UNCFG;
            cfg_reg    <= '0;
            cnt_reg    <= '0;
            err_reg    <= 1'b0;
            q_reg      <= 1'b0;
            q_frac_reg <= 2'b00;
        end else begin
            if (cfg_en) begin
                cfg_reg <= {cfg_reg[N-2:0], cfg_din};
            end

            case (state_reg)
                UNCFG, READY: begin
                    if (cfg_en) begin
                        state_reg <= LOADING;
                        cnt_reg   <= CW'(1);
                        err_reg   <= 1'b0;
                    end
                end
                LOADING: begin
                    if (cfg_en) begin
                        // Overrun bits only pass through toward the next tile.
                        if (cnt_reg != CNT_FULL) begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end else if (cnt_reg == CNT_FULL) begin
                        state_reg <= READY;
                    end else begin
                        state_reg <= UNCFG;
                        err_reg   <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= UNCFG;
                end
            endcase

            if (ff_en) begin
                q_reg      <= lut_gated;
                q_frac_reg <= frac_gated;
            end
        end
    end

    assign cfg_dout = cfg_reg[N-1];
    assign cfg_done = ready;
    assign cfg_err  = err_reg;
    assign lut_out  = lut_gated;
    assign frac_out = frac_gated;
    assign q        = q_reg;
    assign q_frac   = q_frac_reg;

endmodule

// File: tb/tb_frac_lutk_cfg.sv
// Scoreboard bench for frac_lutk_cfg (K=4): stimulus queues expected port values,
// a monitor pops and compares them at the sampling strobe.
module tb_frac_lutk_cfg;

    localparam int K = 4;
    localparam int N = 17;

    localparam int SEL_LUT   = 0;
    localparam int SEL_FRAC  = 1;
    localparam int SEL_Q     = 2;
    localparam int SEL_QFRAC = 3;
    localparam int SEL_DONE  = 4;
    localparam int SEL_ERR   = 5;
    localparam int SEL_DOUT  = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic         cfg_en;
    logic         cfg_din;
    logic         cfg_dout;
    logic         cfg_done;
    logic         cfg_err;
    logic [K-1:0] in;
    logic         ff_en;
    logic         lut_out;
    logic [1:0]   frac_out;
    logic         q;
    logic [1:0]   q_frac;

    logic chk_stb   = 1'b0;
    logic async_stb = 1'b0;

    int tests_run = 0;
    int fails     = 0;

    typedef struct {
        string      name;
        int         sel;
        logic [1:0] exp;
    } item_t;

    item_t sb[$];
    item_t it;
    logic [1:0] act;

    frac_lutk_cfg #(.K(K)) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_en   (cfg_en),
        .cfg_din  (cfg_din),
        .cfg_dout (cfg_dout),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err),
        .in       (in),
        .ff_en    (ff_en),
        .lut_out  (lut_out),
        .frac_out (frac_out),
        .q        (q),
        .q_frac   (q_frac)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] actual(int sel);
        case (sel)
            SEL_LUT:   return {1'b0, lut_out};
            SEL_FRAC:  return frac_out;
            SEL_Q:     return {1'b0, q};
            SEL_QFRAC: return q_frac;
            SEL_DONE:  return {1'b0, cfg_done};
            SEL_ERR:   return {1'b0, cfg_err};
            default:   return {1'b0, cfg_dout};
        endcase
    endfunction

    // Monitor: drains the scoreboard at each sampling strobe.
    always @(negedge clk or posedge async_stb) begin
        if (chk_stb || async_stb) begin
            while (sb.size() > 0) begin
                it  = sb.pop_front();
                act = actual(it.sel);
                tests_run++;
                if (act !== it.exp) begin
                    fails++;
                    $display("FAIL %s: got %0d expected %0d", it.name, act, it.exp);
                end else begin
                    $display("[TB] ok %s = %0d", it.name, act);
                end
            end
        end
    end

    task automatic expect_v(string name, int sel, logic [1:0] v);
        item_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic check_edge();
        chk_stb = 1'b1;
        @(negedge clk);
        #1;
        chk_stb = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_word(logic [N-1:0] w);
        for (int i = N - 1; i >= 0; i--) begin
            cfg_en  = 1'b1;
            cfg_din = w[i];
            tick();
        end
        cfg_en = 1'b0;
    endtask

    task automatic load(logic [N-1:0] w);
        shift_word(w);
        tick();
    endtask

    // Expected values derive from T index {e, in[2:0]}, frac = {T[8+lo], T[lo]}.
    logic [3:0] v_in   [5] = '{4'hF, 4'h0, 4'h1, 4'h8, 4'h9};
    logic       v_lut  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0] v_frac [5] = '{2'd3, 2'd0, 2'd3, 2'd0, 2'd3};

    logic [3:0] f_in   [4] = '{4'h0, 4'h8, 4'h7, 4'hF};
    logic       f_lut  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] f_frac [4] = '{2'd1, 2'd1, 2'd2, 2'd2};

    logic [N-1:0] word_a;
    logic [N-1:0] word_b;

    initial begin
        word_a  = {1'b0, 16'hCAFE};
        word_b  = {1'b1, 16'h8001};
        reset   = 1'b1;
        cfg_en  = 1'b0;
        cfg_din = 1'b0;
        in      = '0;
        ff_en   = 1'b0;

        // Reset and idle
        repeat (2) tick();
        ff_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in = (i == 0) ? 4'hF : 4'h5;
            expect_v("rst_lut", SEL_LUT, 2'd0);
            expect_v("rst_frac", SEL_FRAC, 2'd0);
            expect_v("rst_done", SEL_DONE, 2'd0);
            expect_v("rst_err", SEL_ERR, 2'd0);
            expect_v("rst_dout", SEL_DOUT, 2'd0);
            check_edge();
        end
        tick();
        expect_v("rst_q", SEL_Q, 2'd0);
        expect_v("rst_qfrac", SEL_QFRAC, 2'd0);
        check_edge();
        tick();
        reset = 1'b0;
        ff_en = 1'b0;

        // Full load, mode 0
        shift_word(word_a);
        expect_v("load_done_lag", SEL_DONE, 2'd0);
        check_edge();
        tick();
        expect_v("load_done", SEL_DONE, 2'd1);
        expect_v("load_err", SEL_ERR, 2'd0);
        check_edge();
        for (int i = 0; i < 5; i++) begin
            in = v_in[i];
            expect_v($sformatf("m0_lut_in%0h", v_in[i]), SEL_LUT, {1'b0, v_lut[i]});
            expect_v($sformatf("m0_frac_in%0h", v_in[i]), SEL_FRAC, v_frac[i]);
            check_edge();
        end

        // Output registers
        tick();
        ff_en = 1'b1;
        in    = 4'hF;
        expect_v("reg_q_before", SEL_Q, 2'd0);
        expect_v("reg_lut_now", SEL_LUT, 2'd1);
        check_edge();
        tick();
        in = 4'h0;
        expect_v("reg_q_lag1", SEL_Q, 2'd1);
        expect_v("reg_qfrac_lag1", SEL_QFRAC, 2'd3);
        expect_v("reg_lut_now0", SEL_LUT, 2'd0);
        check_edge();
        tick();
        expect_v("reg_q_lag0", SEL_Q, 2'd0);
        expect_v("reg_qfrac_lag0", SEL_QFRAC, 2'd0);
        check_edge();
        tick();
        ff_en = 1'b0;
        in    = 4'hF;
        tick();
        tick();
        expect_v("reg_q_hold", SEL_Q, 2'd0);
        expect_v("reg_lut_hold", SEL_LUT, 2'd1);
        check_edge();

        // Short load
        tick();
        for (int i = 0; i < 10; i++) begin
            cfg_en  = 1'b1;
            cfg_din = 1'b1;
            tick();
            if (i == 0) begin
                expect_v("short_done_drop", SEL_DONE, 2'd0);
                expect_v("short_lut_gated", SEL_LUT, 2'd0);
                check_edge();
            end
        end
        cfg_en = 1'b0;
        tick();
        expect_v("short_err", SEL_ERR, 2'd1);
        expect_v("short_done", SEL_DONE, 2'd0);
        expect_v("short_lut", SEL_LUT, 2'd0);
        expect_v("short_frac", SEL_FRAC, 2'd0);
        check_edge();
        tick();
        shift_word(word_a);
        expect_v("reload_err_clr", SEL_ERR, 2'd0);
        tick();
        expect_v("reload_done", SEL_DONE, 2'd1);
        expect_v("reload_lut", SEL_LUT, 2'd1);
        check_edge();

        // Fractured mode
        tick();
        load(word_b);
        for (int i = 0; i < 4; i++) begin
            in = f_in[i];
            expect_v($sformatf("m1_lut_in%0h", f_in[i]), SEL_LUT, {1'b0, f_lut[i]});
            expect_v($sformatf("m1_frac_in%0h", f_in[i]), SEL_FRAC, f_frac[i]);
            check_edge();
        end

        // Chaining and overrun: 34 shifts, A then B
        tick();
        for (int k = 1; k <= 2 * N; k++) begin
            cfg_en  = 1'b1;
            cfg_din = (k <= N) ? word_a[N-k] : word_b[2*N-k];
            if (k > N) begin
                expect_v($sformatf("chain_dout_s%0d", k), SEL_DOUT, {1'b0, word_a[2*N-k]});
                check_edge();
            end
            tick();
        end
        cfg_en = 1'b0;
        tick();
        expect_v("chain_done", SEL_DONE, 2'd1);
        expect_v("chain_err", SEL_ERR, 2'd0);
        in = 4'h7;
        expect_v("chain_lut_in7", SEL_LUT, 2'd1);
        expect_v("chain_frac_in7", SEL_FRAC, 2'd2);
        check_edge();
        in = 4'h0;
        expect_v("chain_lut_in0", SEL_LUT, 2'd0);
        expect_v("chain_frac_in0", SEL_FRAC, 2'd1);
        check_edge();

        // Async reset during a reload
        tick();
        ff_en = 1'b1;
        in    = 4'h7;
        tick();
        ff_en = 1'b0;
        expect_v("pre_q", SEL_Q, 2'd1);
        expect_v("pre_qfrac", SEL_QFRAC, 2'd2);
        check_edge();
        tick();
        cfg_en  = 1'b1;
        cfg_din = 1'b1;
        tick();
        expect_v("reload_done_drop", SEL_DONE, 2'd0);
        expect_v("reload_q_hold", SEL_Q, 2'd1);
        expect_v("reload_dout", SEL_DOUT, 2'd1);
        check_edge();
        reset = 1'b1;
        #1;
        expect_v("async_q", SEL_Q, 2'd0);
        expect_v("async_qfrac", SEL_QFRAC, 2'd0);
        expect_v("async_done", SEL_DONE, 2'd0);
        expect_v("async_dout", SEL_DOUT, 2'd0);
        async_stb = 1'b1;
        #1;
        async_stb = 1'b0;
        cfg_en    = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        expect_v("post_done", SEL_DONE, 2'd0);
        expect_v("post_err", SEL_ERR, 2'd0);
        expect_v("post_lut", SEL_LUT, 2'd0);
        expect_v("post_dout", SEL_DOUT, 2'd0);
        check_edge();

        tick();
        if (sb.size() != 0) begin
            tests_run++;
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
